prf_wb_arbiter: RTL
===================

// Module: prf_wb_arbiter
// PURPOSE
// - Shares N_OUT physical-register-file write ports among three writeback sources (ALU, LSU, BRU).
// - Each source has its own FIFO, and the FIFO heads are granted round-robin.
// - Sits between the execute units and the PRF write ports.
// - Drives registered wb_pkt_t outputs and per-source stall backpressure.
// - Only carries PRF data/valid updates. ROB completion is signalled separately and is not delayed by this block.
// PARAMETERS
// - FIFO_DEPTH  4  entries per source FIFO, power of two, >= 2
// - N_OUT       2  PRF write ports driven per cycle, 1..3
// PORTS
// - clk          in   1                   clock
// - rst_n        in   1                   reset: synchronous, active-low
// - flush_i      in   1                   pipeline flush; discard all queued writebacks
// - recover_i    in   1                   checkpoint recovery; discard all queued writebacks
// - wb_alu_i     in   wb_pkt_t            ALU writeback request
// - wb_lsu_i     in   wb_pkt_t            LSU writeback request
// - wb_bru_i     in   wb_pkt_t            BRU writeback request
// - stall_o      out  3                   per-source stall [0]=ALU [1]=LSU [2]=BRU, registered
// - wb_out_o     out  wb_pkt_t [N_OUT]    granted writebacks to PRF write ports, registered
// - occ_o        out  3*($clog2(FIFO_DEPTH)+1)  per-source FIFO occupancy, registered
// - overflow_o   out  1                   sticky error: a packet arrived at a full FIFO
// BEHAVIOUR
// - Reset:
//   - FIFOs empty; all wb_out_o[k].valid = 0, other fields 0.
//   - stall_o = 0, occ_o = 0, overflow_o = 0.
//   - Round-robin pointer rr = 0 (ALU).
// - Input filter: a packet is enqueued only if valid && rd_used && prd != 0. All other packets are ignored silently.
// - Enqueue: a filtered packet is written at the FIFO tail at the end of the cycle it is presented.
// - Full FIFO with no pop this cycle:
//   - The packet is dropped and overflow_o is set.
//   - overflow_o is cleared only by reset.
//   - Push to a full FIFO in the same cycle as its pop is legal and is not an overflow.
// - Arbitration:
//   - Each cycle, the non-empty sources are scanned in order rr, rr+1, rr+2 (mod 3).
//   - The first min(N_OUT, #non-empty) sources are granted, one head each.
//   - A source never gets two grants in one cycle.
//   - rr moves to (last granted source + 1) mod 3. rr is unchanged if nothing is granted.
// - Output: granted heads are popped and loaded into wb_out_o[0..] in scan order. Unused slots get valid = 0.
//   - wb_out_o is valid the cycle after the grant.
// - Latency: a packet presented in cycle N to an empty FIFO, with a port free, appears on wb_out_o in cycle N+2. There is no bypass.
// - Ordering: FIFO order is preserved within each source. There is no ordering guarantee across sources.
// - Stall: stall_o[s] is registered high when post-edge occupancy >= FIFO_DEPTH-1. Sources react one cycle late, and the one extra in-flight packet fits.
// - flush_i or recover_i:
//   - All FIFOs are emptied and all wb_out_o valid bits are cleared at the edge.
//   - Same-cycle inputs are dropped; no overflow is flagged.
//   - stall_o is 0 and occ_o is 0 next cycle.
//   - rr is kept.
//   - If both are asserted, the effect is the same.
// - prd collisions between outputs are not checked; rename guarantees they are unique.
// - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Occupancy is one bit wider.
// TESTING
// - Single ALU pkt prd=5 data=0xAA in cycle 1 -> wb_out_o[0] = {valid, prd 5, data 0xAA} in cycle 3; all other slots invalid.
// - ALU, LSU and BRU valid every cycle, N_OUT=2:
//   - Grants rotate {ALU,LSU}, {BRU,ALU}, {LSU,BRU}, ...
//   - Each source gets 2 grants per 3 cycles.
//   - FIFO data order matches input order.
// - LSU pkts every cycle, N_OUT=1, ALU+BRU also busy -> stall_o[1] rises when LSU occupancy reaches 3 (FIFO_DEPTH=4). The source honours stall, overflow_o stays 0.
// - LSU pkt sent to a full FIFO with no grant -> packet is dropped, overflow_o = 1 and stays 1 until reset.
// - 3 entries queued per source, recover_i pulsed with a new BRU pkt in the same cycle:
//   - Next cycle occ_o = 0 and stall_o = 0; no wb_out_o valid for 2 cycles; the BRU pkt is not emitted.
// - Inputs with prd=0 or rd_used=0 -> never enqueued, occ_o unchanged. Reset mid-traffic -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/prf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : prf_wb_arbiter (with package prf_wb_pkg)
//  Purpose  : Per-source writeback FIFOs (ALU/LSU/BRU) whose heads are granted
//             round-robin onto N_OUT registered PRF write ports, with
//             registered stall backpressure, occupancy and sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
package prf_wb_pkg;
  localparam int PRD_W  = 7;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic              valid;
    logic              rd_used;
    logic [PRD_W-1:0]  prd;
    logic [DATA_W-1:0] data;
  } wb_pkt_t;
endpackage

module prf_wb_arbiter
  import prf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int N_OUT      = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush_i,
  input  logic                                 recover_i,
  input  wb_pkt_t                              wb_alu_i,
  input  wb_pkt_t                              wb_lsu_i,
  input  wb_pkt_t                              wb_bru_i,
  output logic [2:0]                           stall_o,
  output wb_pkt_t [N_OUT-1:0]                  wb_out_o,
  output logic [3*($clog2(FIFO_DEPTH)+1)-1:0]  occ_o,
  output logic                                 overflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int EW = PRD_W + DATA_W;

  wb_pkt_t             w_in [3];
  logic [EW-1:0]       r_mem [3][FIFO_DEPTH];
  logic [PW-1:0]       r_rd_ptr [3];
  logic [PW-1:0]       r_wr_ptr [3];
  logic [OW-1:0]       r_occ [3];
  logic [OW-1:0]       w_occ_next [3];
  logic [EW-1:0]       w_head [3];
  logic [1:0]          r_rr;
  logic [1:0]          w_rr_next;
  logic [2:0]          r_stall;
  logic                r_ovf;
  wb_pkt_t [N_OUT-1:0] r_wb_out;
  logic                w_flush;
  logic [2:0]          w_filt;
  logic [2:0]          w_grant;
  logic [2:0]          w_push;
  logic [2:0]          w_ovf;
  logic [N_OUT-1:0]    w_slot_vld;
  logic [1:0]          w_slot_src [N_OUT];

  assign w_in[0] = wb_alu_i;
  assign w_in[1] = wb_lsu_i;
  assign w_in[2] = wb_bru_i;
  assign w_flush = flush_i | recover_i;

  function automatic logic [1:0] f_mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] v_sum;
    v_sum = {1'b0, a} + {1'b0, b};
    if (v_sum >= 3'd3) v_sum = v_sum - 3'd3;
    return v_sum[1:0];
  endfunction

  // Round-robin scan from rr: grant up to N_OUT non-empty heads, assign slots in scan order
  always_comb begin
    logic [1:0] v_src;
    logic [1:0] v_cnt;
    w_grant   = '0;
    w_slot_vld = '0;
    w_rr_next = r_rr;
    v_cnt     = 2'd0;
    v_src     = 2'd0;
    for (int k = 0; k < N_OUT; k++) w_slot_src[k] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      v_src = f_mod3_add(r_rr, 2'(i));
      if ((r_occ[v_src] != '0) && (int'(v_cnt) < N_OUT)) begin
        w_grant[v_src] = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
          if (v_cnt == 2'(k)) begin
            w_slot_vld[k] = 1'b1;
            w_slot_src[k] = v_src;
          end
        end
        v_cnt     = v_cnt + 2'd1;
        w_rr_next = f_mod3_add(v_src, 2'd1);
      end
    end
  end

  // Input filter, push acceptance (a same-cycle pop frees a slot), overflow detect, next occupancy
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      w_filt[s]     = w_in[s].valid & w_in[s].rd_used & (|w_in[s].prd);
      w_push[s]     = ~w_flush & w_filt[s] & ((r_occ[s] != OW'(FIFO_DEPTH)) | w_grant[s]);
      w_ovf[s]      = ~w_flush & w_filt[s] & (r_occ[s] == OW'(FIFO_DEPTH)) & ~w_grant[s];
      w_occ_next[s] = r_occ[s] + OW'(w_push[s]) - OW'(w_grant[s]);
      w_head[s]     = r_mem[s][r_rd_ptr[s]];
    end
  end

  // FIFO storage writes; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (w_push[s]) r_mem[s][r_wr_ptr[s]] <= {w_in[s].prd, w_in[s].data};
    end
  end

  // Pointer, occupancy, round-robin and registered-output state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        r_rd_ptr[s] <= '0;
        r_wr_ptr[s] <= '0;
        r_occ[s]    <= '0;
      end
      r_rr     <= 2'd0;
      r_stall  <= 3'b000;
      r_ovf    <= 1'b0;
      r_wb_out <= '0;
    end else if (w_flush) begin
      // Discard everything queued and in the output stage; rr and the sticky flag survive
      for (int s = 0; s < 3; s++) begin
        r_rd_ptr[s] <= '0;
        r_wr_ptr[s] <= '0;
        r_occ[s]    <= '0;
      end
      r_stall  <= 3'b000;
      r_wb_out <= '0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (w_push[s])  r_wr_ptr[s] <= r_wr_ptr[s] + PW'(1);
        if (w_grant[s]) r_rd_ptr[s] <= r_rd_ptr[s] + PW'(1);
        r_occ[s]   <= w_occ_next[s];
        r_stall[s] <= (w_occ_next[s] >= OW'(FIFO_DEPTH - 1));
      end
      r_rr  <= w_rr_next;
      r_ovf <= r_ovf | (|w_ovf);
      for (int k = 0; k < N_OUT; k++) begin
        if (w_slot_vld[k]) begin
          r_wb_out[k] <= {1'b1, 1'b1, w_head[w_slot_src[k]]};
        end else begin
          r_wb_out[k] <= '0;
        end
      end
    end
  end

  for (genvar s = 0; s < 3; s++) begin : g_occ
    assign occ_o[s*OW +: OW] = r_occ[s];
  end

  assign stall_o    = r_stall;
  assign wb_out_o   = r_wb_out;
  assign overflow_o = r_ovf;

endmodule
`default_nettype wire
